// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory-port arbiter.
package arb_pkg;

    // Default number of consecutive data grants allowed while a fetch waits.
    localparam int unsigned ARB_STARVE_LIMIT = 4;

    // Arbiter FSM states: idle, or busy serving the data or the fetch port.
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_D = 2'd1,
        ARB_BUSY_I = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the pipeline request ports and the shared backend port.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    // data (MEM-stage) port
    logic              d_rd_en;
    logic              d_wr_en;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;
    // instruction-fetch port
    logic              i_rd_en;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;
    // backend (cache/SRAM) port
    logic              m_rd_en;
    logic              m_wr_en;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              m_ready;

    modport slave (
        input  d_rd_en, d_wr_en, d_addr, d_wdata, i_rd_en, i_addr, m_rdata, m_ready,
        output d_rdata, d_ready, i_rdata, i_ready, m_rd_en, m_wr_en, m_addr, m_wdata
    );

    modport master (
        output d_rd_en, d_wr_en, d_addr, d_wdata, i_rd_en, i_addr, m_rdata, m_ready,
        input  d_rdata, d_ready, i_rdata, i_ready, m_rd_en, m_wr_en, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one memory backend between fetch and data ports.
// Data has priority; a saturating starvation counter forces a fetch grant
// after STARVE_LIMIT consecutive data grants taken while a fetch waited.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam int unsigned      CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    arb_state_e        state_q,      state_d;
    logic              m_rd_en_q,    m_rd_en_d;
    logic              m_wr_en_q,    m_wr_en_d;
    logic [ADDR_W-1:0] m_addr_q,     m_addr_d;
    logic [DATA_W-1:0] m_wdata_q,    m_wdata_d;
    logic [DATA_W-1:0] d_hold_q,     d_hold_d;
    logic [DATA_W-1:0] i_hold_q,     i_hold_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;

    logic d_req_s;
    logic fetch_wins_s;
    logic d_done_s;
    logic i_done_s;

    assign d_req_s      = bus.d_rd_en | bus.d_wr_en;
    // A lone fetch always wins; against data it wins only once starved.
    assign fetch_wins_s = bus.i_rd_en & (~d_req_s | (starve_cnt_q == CNT_MAX));
    assign d_done_s     = (state_q == ARB_BUSY_D) & bus.m_ready;
    assign i_done_s     = (state_q == ARB_BUSY_I) & bus.m_ready;

    // Ready doubles as the pipeline freeze: an idle port is never frozen.
    assign bus.d_ready  = ~d_req_s | d_done_s;
    assign bus.i_ready  = ~bus.i_rd_en | i_done_s;

    assign bus.m_rd_en  = m_rd_en_q;
    assign bus.m_wr_en  = m_wr_en_q;
    assign bus.m_addr   = m_addr_q;
    assign bus.m_wdata  = m_wdata_q;

    // Read data bypass: backend data in the completion cycle, else the hold register.
    always_comb begin
        bus.d_rdata = d_hold_q;
        bus.i_rdata = i_hold_q;
        if (d_done_s && m_rd_en_q) begin
            bus.d_rdata = bus.m_rdata;
        end else begin
            bus.d_rdata = d_hold_q;
        end
        if (i_done_s) begin
            bus.i_rdata = bus.m_rdata;
        end else begin
            bus.i_rdata = i_hold_q;
        end
    end

    // Next-state logic: grant in IDLE, hold the access while busy, finish on m_ready.
    always_comb begin
        state_d      = state_q;
        m_rd_en_d    = m_rd_en_q;
        m_wr_en_d    = m_wr_en_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        d_hold_d     = d_hold_q;
        i_hold_d     = i_hold_q;
        starve_cnt_d = starve_cnt_q;

        case (state_q)
            ARB_IDLE: begin
                if (fetch_wins_s) begin
                    state_d      = ARB_BUSY_I;
                    m_rd_en_d    = 1'b1;
                    m_wr_en_d    = 1'b0;
                    m_addr_d     = bus.i_addr;
                    m_wdata_d    = '0;
                    starve_cnt_d = '0;
                end else if (d_req_s) begin
                    state_d   = ARB_BUSY_D;
                    // read+write together is treated as a write
                    m_wr_en_d = bus.d_wr_en;
                    m_rd_en_d = bus.d_rd_en & ~bus.d_wr_en;
                    m_addr_d  = bus.d_addr;
                    m_wdata_d = bus.d_wdata;
                    if (!bus.i_rd_en) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != CNT_MAX) begin
                        starve_cnt_d = starve_cnt_q + CNT_ONE;
                    end else begin
                        starve_cnt_d = starve_cnt_q;
                    end
                end else begin
                    // no request at all, so no fetch is waiting
                    starve_cnt_d = '0;
                end
            end
            ARB_BUSY_D: begin
                if (bus.m_ready) begin
                    state_d   = ARB_IDLE;
                    m_rd_en_d = 1'b0;
                    m_wr_en_d = 1'b0;
                    if (m_rd_en_q) begin
                        d_hold_d = bus.m_rdata;
                    end else begin
                        d_hold_d = d_hold_q;
                    end
                end else begin
                    state_d = ARB_BUSY_D;
                end
            end
            ARB_BUSY_I: begin
                if (bus.m_ready) begin
                    state_d   = ARB_IDLE;
                    m_rd_en_d = 1'b0;
                    m_wr_en_d = 1'b0;
                    i_hold_d  = bus.m_rdata;
                end else begin
                    state_d = ARB_BUSY_I;
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                m_rd_en_d = 1'b0;
                m_wr_en_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any access in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ARB_IDLE;
            m_rd_en_q    <= 1'b0;
            m_wr_en_q    <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            d_hold_q     <= '0;
            i_hold_q     <= '0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            m_rd_en_q    <= m_rd_en_d;
            m_wr_en_q    <= m_wr_en_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            d_hold_q     <= d_hold_d;
            i_hold_q     <= i_hold_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a fixed-latency backend model.
module tb_mem_port_arbiter;
    import arb_pkg::*;

    localparam int LAT = 3;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    logic clk;
    logic rst;
    logic stray_rdy;
    int   cyc;
    int   be_cnt;
    int   n_checks;
    int   n_fail;
    exp_t exp_d_q[$];
    exp_t exp_i_q[$];
    exp_t mon_e;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Memory contents seen by the backend model.
    function automatic logic [31:0] pat(input logic [31:0] a);
        if (a == 32'h0000_0400) return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Backend: completes LAT cycles after an enable first rises.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) be_cnt <= 0;
        else if ((bus.m_rd_en | bus.m_wr_en) && !bus.m_ready) be_cnt <= be_cnt + 1;
        else be_cnt <= 0;
    end

    always_comb begin
        bus.m_ready = ((bus.m_rd_en | bus.m_wr_en) && (be_cnt == LAT - 1)) | stray_rdy;
        bus.m_rdata = pat(bus.m_addr);
    end

    // Scoreboard: pop the expected access on every backend completion.
    always @(negedge clk) begin
        if (rst && (bus.m_rd_en | bus.m_wr_en) && bus.m_ready) begin
            if (dut.state_q == ARB_BUSY_D) begin
                n_checks++;
                if (exp_d_q.size() == 0) begin
                    n_fail++; $display("FAIL sb_d_unexpected: got access addr %h, required none", bus.m_addr);
                end else begin
                    mon_e = exp_d_q.pop_front();
                    n_checks++;
                    if (bus.m_addr !== mon_e.addr || bus.m_wr_en !== mon_e.wr || bus.m_rd_en !== !mon_e.wr) begin
                        n_fail++; $display("FAIL sb_d_op: got addr %h wr %b rd %b, required addr %h wr %b", bus.m_addr, bus.m_wr_en, bus.m_rd_en, mon_e.addr, mon_e.wr);
                    end
                    n_checks++;
                    if (mon_e.wr && bus.m_wdata !== mon_e.wdata) begin
                        n_fail++; $display("FAIL sb_d_wdata: got %h, required %h", bus.m_wdata, mon_e.wdata);
                    end else if (!mon_e.wr && bus.d_rdata !== mon_e.rdata) begin
                        n_fail++; $display("FAIL sb_d_rdata: got %h, required %h", bus.d_rdata, mon_e.rdata);
                    end
                    n_checks++;
                    if (bus.d_ready !== 1'b1) begin
                        n_fail++; $display("FAIL sb_d_ready: got %b, required 1", bus.d_ready);
                    end
                end
            end else if (dut.state_q == ARB_BUSY_I) begin
                n_checks++;
                if (exp_i_q.size() == 0) begin
                    n_fail++; $display("FAIL sb_i_unexpected: got fetch addr %h, required none", bus.m_addr);
                end else begin
                    mon_e = exp_i_q.pop_front();
                    n_checks++;
                    if (bus.m_addr !== mon_e.addr || bus.m_rd_en !== 1'b1 || bus.m_wr_en !== 1'b0) begin
                        n_fail++; $display("FAIL sb_i_op: got addr %h rd %b wr %b, required addr %h rd 1", bus.m_addr, bus.m_rd_en, bus.m_wr_en, mon_e.addr);
                    end
                    n_checks++;
                    if (bus.i_rdata !== mon_e.rdata || bus.i_ready !== 1'b1) begin
                        n_fail++; $display("FAIL sb_i_rdata: got %h ready %b, required %h ready 1", bus.i_rdata, bus.i_ready, mon_e.rdata);
                    end
                end
            end
        end
    end

    // Data requester: hold request until d_ready, then drop it after the edge.
    task automatic drive_d(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, output int done_cyc);
        exp_t e;
        e.wr = wr; e.addr = addr; e.wdata = wdata; e.rdata = pat(addr);
        exp_d_q.push_back(e);
        bus.d_rd_en = rd; bus.d_wr_en = wr; bus.d_addr = addr; bus.d_wdata = wdata;
        done_cyc = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.d_ready) begin done_cyc = cyc; break; end
        end
        n_checks++;
        if (done_cyc < 0) begin
            n_fail++; $display("FAIL d_timeout: got no d_ready for addr %h, required within 50 cycles", addr);
        end
        @(posedge clk); #1;
        bus.d_rd_en = 1'b0; bus.d_wr_en = 1'b0;
    endtask

    // Fetch requester: hold request until i_ready, then drop it after the edge.
    task automatic drive_i(input logic [31:0] addr, output int done_cyc);
        exp_t e;
        e.wr = 1'b0; e.addr = addr; e.wdata = 32'h0; e.rdata = pat(addr);
        exp_i_q.push_back(e);
        bus.i_rd_en = 1'b1; bus.i_addr = addr;
        done_cyc = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.i_ready) begin done_cyc = cyc; break; end
        end
        n_checks++;
        if (done_cyc < 0) begin
            n_fail++; $display("FAIL i_timeout: got no i_ready for addr %h, required within 50 cycles", addr);
        end
        @(posedge clk); #1;
        bus.i_rd_en = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (bus.m_rd_en !== 1'b0 || bus.m_wr_en !== 1'b0 || bus.m_addr !== 32'h0 || bus.m_wdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_m: got rd %b wr %b addr %h wdata %h, required all 0", bus.m_rd_en, bus.m_wr_en, bus.m_addr, bus.m_wdata);
        end
        n_checks++;
        if (bus.d_ready !== 1'b1 || bus.i_ready !== 1'b1 || bus.d_rdata !== 32'h0 || bus.i_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_ports: got d_ready %b i_ready %b d_rdata %h i_rdata %h, required 1 1 0 0", bus.d_ready, bus.i_ready, bus.d_rdata, bus.i_rdata);
        end
    endtask

    task automatic test_data_read();
        exp_t e;
        e.wr = 1'b0; e.addr = 32'h400; e.wdata = 32'h0; e.rdata = 32'hDEAD_BEEF;
        exp_d_q.push_back(e);
        bus.d_rd_en = 1'b1; bus.d_addr = 32'h400;
        @(negedge clk);
        n_checks++;
        if (bus.m_rd_en !== 1'b0 || bus.d_ready !== 1'b0) begin
            n_fail++; $display("FAIL rd_cycle0: got m_rd_en %b d_ready %b, required 0 0", bus.m_rd_en, bus.d_ready);
        end
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.m_rd_en !== 1'b1 || bus.m_addr !== 32'h400 || bus.d_ready !== (k == LAT) || bus.i_ready !== 1'b1) begin
                n_fail++; $display("FAIL rd_cycle%0d: got m_rd_en %b addr %h d_ready %b i_ready %b, required 1 400 %b 1", k, bus.m_rd_en, bus.m_addr, bus.d_ready, bus.i_ready, (k == LAT));
            end
        end
        n_checks++;
        if (bus.d_rdata !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL rd_data: got %h, required deadbeef", bus.d_rdata);
        end
        @(posedge clk); #1;
        bus.d_rd_en = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.m_rd_en !== 1'b0 || bus.d_rdata !== 32'hDEAD_BEEF || bus.d_ready !== 1'b1) begin
            n_fail++; $display("FAIL rd_after: got m_rd_en %b d_rdata %h d_ready %b, required 0 deadbeef 1", bus.m_rd_en, bus.d_rdata, bus.d_ready);
        end
    endtask

    task automatic test_data_write();
        int t0;
        int t1;
        fork
            drive_d(1'b1, 1'b1, 32'h404, 32'h1234_5678, t0);
            begin
                repeat (2) @(negedge clk);
                n_checks++;
                if (bus.m_wr_en !== 1'b1 || bus.m_rd_en !== 1'b0 || bus.m_addr !== 32'h404 || bus.m_wdata !== 32'h1234_5678) begin
                    n_fail++; $display("FAIL wr_both: got wr %b rd %b addr %h wdata %h, required 1 0 404 12345678", bus.m_wr_en, bus.m_rd_en, bus.m_addr, bus.m_wdata);
                end
            end
        join
        drive_d(1'b0, 1'b1, 32'h408, 32'hCAFE_F00D, t1);
        n_checks++;
        if (t1 - t0 !== LAT + 1) begin
            n_fail++; $display("FAIL wr_throughput: got spacing %0d, required %0d", t1 - t0, LAT + 1);
        end
    endtask

    task automatic test_stray_ready();
        stray_rdy = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.d_rdata !== 32'hDEAD_BEEF || bus.d_ready !== 1'b1 || bus.m_rd_en !== 1'b0 || bus.m_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL stray_idle: got d_rdata %h d_ready %b rd %b wr %b, required deadbeef 1 0 0", bus.d_rdata, bus.d_ready, bus.m_rd_en, bus.m_wr_en);
        end
        @(posedge clk); #1;
        stray_rdy = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.d_rdata !== 32'hDEAD_BEEF || bus.m_rd_en !== 1'b0 || bus.m_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL stray_after: got d_rdata %h rd %b wr %b, required deadbeef 0 0", bus.d_rdata, bus.m_rd_en, bus.m_wr_en);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_concurrent();
        int td;
        int ti;
        fork
            drive_d(1'b1, 1'b0, 32'h500, 32'h0, td);
            drive_i(32'h100, ti);
        join
        n_checks++;
        if (ti - td !== LAT + 1) begin
            n_fail++; $display("FAIL conc_order: got fetch-data spacing %0d, required %0d", ti - td, LAT + 1);
        end
        @(negedge clk);
        n_checks++;
        if (bus.i_rdata !== pat(32'h100) || bus.d_rdata !== pat(32'h500)) begin
            n_fail++; $display("FAIL conc_hold: got i %h d %h, required %h %h", bus.i_rdata, bus.d_rdata, pat(32'h100), pat(32'h500));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_starvation();
        int ti;
        int td[6];
        int n_before;
        fork
            begin
                drive_i(32'h140, ti);
                n_checks++;
                if (dut.starve_cnt_q !== 0) begin
                    n_fail++; $display("FAIL starve_clear: got %0d, required 0", dut.starve_cnt_q);
                end
            end
            begin
                for (int k = 0; k < 6; k++) drive_d(1'b1, 1'b0, 32'h600 + 32'(k * 4), 32'h0, td[k]);
            end
        join
        n_before = 0;
        for (int k = 0; k < 6; k++) if (td[k] < ti) n_before++;
        n_checks++;
        if (n_before !== 4) begin
            n_fail++; $display("FAIL starve_grants: got %0d data grants before fetch, required 4", n_before);
        end
        n_checks++;
        if (ti - td[3] !== LAT + 1 || td[4] - ti !== LAT + 1 || td[1] - td[0] !== LAT + 1) begin
            n_fail++; $display("FAIL starve_timing: got %0d %0d %0d, required %0d each", ti - td[3], td[4] - ti, td[1] - td[0], LAT + 1);
        end
    endtask

    task automatic test_addr_hold();
        exp_t e;
        e.wr = 1'b0; e.addr = 32'h400; e.wdata = 32'h0; e.rdata = 32'hDEAD_BEEF;
        exp_d_q.push_back(e);
        bus.d_rd_en = 1'b1; bus.d_addr = 32'h400;
        @(posedge clk); #1;
        bus.d_addr = 32'h800;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.m_addr !== 32'h400 || bus.m_rd_en !== 1'b1) begin
                n_fail++; $display("FAIL addr_hold%0d: got addr %h rd %b, required 400 1", k, bus.m_addr, bus.m_rd_en);
            end
        end
        @(posedge clk); #1;
        bus.d_rd_en = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        bus.i_rd_en = 1'b1; bus.i_addr = 32'h200;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.m_rd_en !== 1'b0 || bus.m_wr_en !== 1'b0 || bus.m_addr !== 32'h0 || bus.m_wdata !== 32'h0) begin
            n_fail++; $display("FAIL rstmid_m: got rd %b wr %b addr %h wdata %h, required all 0", bus.m_rd_en, bus.m_wr_en, bus.m_addr, bus.m_wdata);
        end
        @(negedge clk);
        n_checks++;
        if (bus.i_ready !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_pulse: got i_ready %b, required 0", bus.i_ready);
        end
        @(posedge clk); #1;
        bus.i_rd_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dut.state_q !== ARB_IDLE || bus.m_rd_en !== 1'b0 || bus.i_ready !== 1'b1 || bus.i_rdata !== 32'h0) begin
            n_fail++; $display("FAIL rstmid_after: got state %0d rd %b i_ready %b i_rdata %h, required 0 0 1 0", dut.state_q, bus.m_rd_en, bus.i_ready, bus.i_rdata);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc = 0; n_checks = 0; n_fail = 0;
        rst = 1'b0; stray_rdy = 1'b0;
        bus.d_rd_en = 1'b0; bus.d_wr_en = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
        bus.i_rd_en = 1'b0; bus.i_addr = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        test_reset();
        @(posedge clk); #1;
        test_data_read();
        @(posedge clk); #1;
        test_data_write();
        test_stray_ready();
        test_concurrent();
        test_starvation();
        test_addr_hold();
        test_reset_mid();
        n_checks++;
        if (exp_d_q.size() != 0 || exp_i_q.size() != 0) begin
            n_fail++; $display("FAIL sb_leftover: got %0d data %0d fetch pending, required 0 0", exp_d_q.size(), exp_i_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-port arbiter that shares the single cache/SRAM data-memory backend between the instruction-fetch port and the MEM-stage data port of the ARM pipeline. It latches the granted request, drives the backend until it signals completion, and returns per-port `ready` signals that the pipeline uses as freeze (`~ready`). The data port has priority, and a bounded starvation counter guarantees forward progress for fetch.

## Interface
- `ADDR_W`, 32, address width of both ports and backend
- `DATA_W`, 32, data width
- `STARVE_LIMIT`, 4, maximum consecutive data grants while a fetch is pending (>=1)

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset; asynchronous, active-low
- `d_rd_en`, `d_wr_en`  in  1 each  data-port read / write request (level, held until `d_ready`)
- `d_addr`  in  ADDR_W  data-port byte address
- `d_wdata`  in  DATA_W  data-port store data
- `d_rdata`  out  DATA_W  data-port load result
- `d_ready`  out  1  data port may advance
- `i_rd_en`  in  1  fetch request (level, held until `i_ready`)
- `i_addr`  in  ADDR_W  fetch address
- `i_rdata`  out  DATA_W  fetched word
- `i_ready`  out  1  fetch port may advance
- `m_rd_en`, `m_wr_en`  out  1 each  backend read / write enable (registered)
- `m_addr`  out  ADDR_W  backend address (registered)
- `m_wdata`  out  DATA_W  backend write data (registered)
- `m_rdata`  in  DATA_W  backend read data, valid when `m_ready`=1
- `m_ready`  in  1  backend completion; only meaningful while an enable is high

## Operation
- FSM states: IDLE, BUSY_D, BUSY_I.
- IDLE, no request: stay. Request(s) present: grant, latch op/address/wdata into `m_*`, and go to BUSY_D or BUSY_I.
- Grant rule: data wins unless `i_rd_en`=1 and `starve_cnt`==STARVE_LIMIT, in which case fetch wins. A lone request is always granted.
- `starve_cnt` (width `$clog2(STARVE_LIMIT+1)`, saturating): +1 on each data grant while `i_rd_en`=1; cleared on a fetch grant, or in any IDLE cycle with `i_rd_en`=0.
- `d_rd_en`=`d_wr_en`=1 is treated as a write (`m_wr_en`=1, `m_rd_en`=0).
- BUSY_x: `m_*` held constant regardless of input changes. On `m_ready`=1: completion, capture `m_rdata` into the port's hold register (reads only), clear enables, go to IDLE.
- `m_ready` in IDLE is ignored.
- `d_ready` = ~(`d_rd_en`|`d_wr_en`) | (state==BUSY_D & `m_ready`). `i_ready` = ~`i_rd_en` | (state==BUSY_I & `m_ready`).
- `d_rdata` = `m_rdata` in the completion cycle of a BUSY_D read; otherwise the hold register. `i_rdata` follows the same rule for BUSY_I.
- Dropping a request mid-access is a protocol violation. The latched access still completes, and its ready pulse is discarded by the requester.

## Timing
- Reset (async assert, sync release): state IDLE; `m_rd_en`, `m_wr_en`, `m_addr`, `m_wdata`, both hold registers, and `starve_cnt` are 0. `d_ready`/`i_ready` then follow their combinational equations (1 when the port is idle).
- Reset mid-access aborts the access with no completion pulse. The backend shares `rst`.
- Request seen in IDLE at cycle N: enable high from cycle N+1. Backend latency L: `m_ready` arrives at cycle N+L, and ready/data reach the requester in that same cycle.
- Enables are low for at least one cycle between accesses (IDLE turnaround). Peak throughput is one access per L+1 cycles.
- The pipeline advances on the completion edge. The next request is evaluated in the following IDLE cycle.

## Structure
- Shared package `arb_pkg`: state enum (`ARB_IDLE`, `ARB_BUSY_D`, `ARB_BUSY_I`) and default `STARVE_LIMIT`.
- Single module, no sub-module. Instantiated in the memory top between the pipeline ports and the cache.

## Test plan
- Lone data read, backend L=3, `d_addr`=0x400, `m_rdata`=0xDEADBEEF -> `m_rd_en` high for cycles 1..3; `d_ready`=1 and `d_rdata`=0xDEADBEEF in cycle 3; `i_ready` stays 1.
- Lone data write, `d_addr`=0x404, `d_wdata`=0x12345678 -> `m_wr_en`=1 with matching addr/data held; both `d_rd_en`/`d_wr_en` high gives `m_rd_en`=0.
- Fetch and data requested in the same cycle -> data granted first; fetch granted in the IDLE cycle after data completes; `i_rdata` correct.
- Continuous data requests with `i_rd_en` held, STARVE_LIMIT=4 -> exactly 4 data grants, then 1 fetch grant; `starve_cnt` returns to 0.
- Change `d_addr` 0x400->0x800 during BUSY_D -> `m_addr` stays 0x400 until completion.
- Assert `rst`=0 in the middle of BUSY_I -> all `m_*` outputs 0 immediately; state IDLE after release; no `i_ready` completion pulse.
